// File: rtl/row_fifo.sv
// row_fifo: first-word-fall-through row buffer built on a register array.
// Rows are written on in_valid && in_ready and popped on out_valid && out_ready.
// in_ready and out_valid come only from registered state, never from in_valid
// or out_ready, so the FIFO breaks the handshake timing path in both directions.
// Optional feature: define ROW_FIFO_HIGH_WATER_EN to add the 'peak' output.
// 'peak' tracks the highest occupancy seen since the last rst or flush.
// DEPTH must be a power of two, 2 or more, so that the pointers wrap for free.
module row_fifo #(
   parameter int WIDTH = 25,
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
`ifdef ROW_FIFO_HIGH_WATER_EN
   ,
   output logic [CW-1:0]    peak
`endif
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push;
   logic             pop;

   // Status flags and handshakes are decoded purely from the registered count.
   always_comb begin
      full      = (count_q == CW'(DEPTH));
      empty     = (count_q == '0);
      in_ready  = !full;
      out_valid = !empty;
      out_data  = mem_q[rd_ptr_q];
      count     = count_q;
      push      = in_valid && in_ready && !flush;
      pop       = out_valid && out_ready && !flush;
   end

   // Pointer and occupancy next-state; flush wins over any push or pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   // Row storage next-state: only the slot under the write pointer changes, and only on a push.
   always_comb begin
      mem_d = mem_q;
      if (push && !rst) begin
         mem_d[wr_ptr_q] = in_data;
      end
   end

   // Control registers with synchronous reset that overrides flush, push and pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Row storage has no reset; stale rows are unreachable once the pointers are cleared.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

`ifdef ROW_FIFO_HIGH_WATER_EN
   logic [CW-1:0] peak_q, peak_d;

   // High-water mark follows the count one edge later and is cleared by flush.
   always_comb begin
      peak_d = peak_q;
      if (count_q > peak_q) begin
         peak_d = count_q;
      end
      if (flush) begin
         peak_d = '0;
      end
   end

   // High-water register, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         peak_q <= '0;
      end else begin
         peak_q <= peak_d;
      end
   end

   assign peak = peak_q;
`endif

endmodule

// File: tb/tb_row_fifo.sv
// tb_row_fifo: table-driven vectors plus hand sequences for row_fifo (WIDTH=25, DEPTH=4).
// A queue scoreboard holds the rows the FIFO should contain; it is updated at every
// clock edge from the driven inputs and compared against the outputs on the falling edge.
// Build with ROW_FIFO_HIGH_WATER_EN defined to also check the peak output.
module tb_row_fifo;

   localparam int WIDTH = 25;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic [CW-1:0]    count;
   logic             full;
   logic             empty;
`ifdef ROW_FIFO_HIGH_WATER_EN
   logic [CW-1:0]    peak;
`endif

   int total = 0;
   int bad   = 0;
   logic [WIDTH-1:0] sb [$];
   int peak_m = 0;

   typedef struct {
      logic             iv;
      logic [WIDTH-1:0] d;
      logic             ordy;
      int               exp_count;
      logic             exp_valid;
      logic [WIDTH-1:0] exp_head;
   } vec_t;

   vec_t vecs [10];

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   row_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .count     (count),
      .full      (full),
      .empty     (empty)
`ifdef ROW_FIFO_HIGH_WATER_EN
      ,
      .peak      (peak)
`endif
   );

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Compare every visible output against the scoreboard state.
   task automatic checkOutput(input string tag);
      int n;
      n = sb.size();
      cmp({tag, "_count"}, 32'(count), 32'(n));
      cmp({tag, "_full"}, 32'(full), 32'(n == DEPTH));
      cmp({tag, "_empty"}, 32'(empty), 32'(n == 0));
      cmp({tag, "_in_ready"}, 32'(in_ready), 32'(n != DEPTH));
      cmp({tag, "_out_valid"}, 32'(out_valid), 32'(n != 0));
      if (n > 0) begin
         cmp({tag, "_out_data"}, 32'(out_data), 32'(sb[0]));
      end
`ifdef ROW_FIFO_HIGH_WATER_EN
      cmp({tag, "_peak"}, 32'(peak), 32'(peak_m));
`endif
   endtask

   // Drive one cycle of inputs, advance the scoreboard at the edge, then check.
   task automatic applyStimulus(input string tag, input logic iv, input logic [WIDTH-1:0] d,
                                input logic ordy, input logic fl, input logic rs);
      int n;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      rst       = rs;
      @(posedge clk);
      n = sb.size();
      if (rs || fl) begin
         sb.delete();
         peak_m = 0;
      end else begin
         if (n > peak_m) peak_m = n;
         if (ordy && n > 0) void'(sb.pop_front());
         if (iv && n < DEPTH) sb.push_back(d);
      end
      @(negedge clk);
      checkOutput(tag);
   endtask

   task automatic doReset();
      applyStimulus("rst", 1'b0, '0, 1'b0, 1'b0, 1'b1);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

      // Fill past full, then drain past empty; the fifth row must never appear.
      vecs[0] = '{1'b1, 25'h1ABCDEF, 1'b0, 1, 1'b1, 25'h1ABCDEF};
      vecs[1] = '{1'b1, 25'h0000001, 1'b0, 2, 1'b1, 25'h1ABCDEF};
      vecs[2] = '{1'b1, 25'h1FFFFFF, 1'b0, 3, 1'b1, 25'h1ABCDEF};
      vecs[3] = '{1'b1, 25'h0000123, 1'b0, 4, 1'b1, 25'h1ABCDEF};
      vecs[4] = '{1'b1, 25'h0000BAD, 1'b0, 4, 1'b1, 25'h1ABCDEF};
      vecs[5] = '{1'b0, 25'h0000000, 1'b1, 3, 1'b1, 25'h0000001};
      vecs[6] = '{1'b0, 25'h0000000, 1'b1, 2, 1'b1, 25'h1FFFFFF};
      vecs[7] = '{1'b0, 25'h0000000, 1'b1, 1, 1'b1, 25'h0000123};
      vecs[8] = '{1'b0, 25'h0000000, 1'b1, 0, 1'b0, 25'h0000000};
      vecs[9] = '{1'b0, 25'h0000000, 1'b1, 0, 1'b0, 25'h0000000};

      doReset();
      doReset();
      cmp("reset_count", 32'(count), 32'd0);
      cmp("reset_empty", 32'(empty), 32'd1);
      cmp("reset_full", 32'(full), 32'd0);
      cmp("reset_in_ready", 32'(in_ready), 32'd1);
      cmp("reset_out_valid", 32'(out_valid), 32'd0);

      for (int i = 0; i < 10; i++) begin
         applyStimulus($sformatf("vec%0d", i), vecs[i].iv, vecs[i].d, vecs[i].ordy, 1'b0, 1'b0);
         cmp($sformatf("vec%0d_tcount", i), 32'(count), 32'(vecs[i].exp_count));
         cmp($sformatf("vec%0d_tvalid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
         if (vecs[i].exp_valid) begin
            cmp($sformatf("vec%0d_thead", i), 32'(out_data), 32'(vecs[i].exp_head));
         end
      end

      // Continuous streaming: occupancy stays at one and pointers wrap twice.
      doReset();
      for (int v = 1; v <= 10; v++) begin
         applyStimulus($sformatf("stream%0d", v), 1'b1, WIDTH'(v), 1'b1, 1'b0, 1'b0);
         cmp($sformatf("stream%0d_cnt1", v), 32'(count), 32'd1);
         cmp($sformatf("stream%0d_head", v), 32'(out_data), 32'(v));
      end
      applyStimulus("stream_drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
      cmp("stream_drain_empty", 32'(empty), 32'd1);

      // At full, a simultaneous offer and take is a pop only; the push lands next cycle.
      doReset();
      for (int v = 1; v <= 4; v++) begin
         applyStimulus("fill4", 1'b1, WIDTH'(32'hA0 + v), 1'b0, 1'b0, 1'b0);
      end
      cmp("full_flag", 32'(full), 32'd1);
      applyStimulus("full_both", 1'b1, 25'h00000A5, 1'b1, 1'b0, 1'b0);
      cmp("full_both_cnt3", 32'(count), 32'd3);
      applyStimulus("full_retry", 1'b1, 25'h00000A5, 1'b0, 1'b0, 1'b0);
      cmp("full_retry_cnt4", 32'(count), 32'd4);
      for (int v = 0; v < 4; v++) begin
         applyStimulus("full_drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
      end

      // Flush overrides a concurrent push; the next push is the next output.
      doReset();
      for (int v = 1; v <= 3; v++) begin
         applyStimulus("pre_flush", 1'b1, WIDTH'(32'h30 + v), 1'b0, 1'b0, 1'b0);
      end
      applyStimulus("flush", 1'b1, 25'h0000099, 1'b0, 1'b1, 1'b0);
      flush = 1'b0;
      cmp("flush_count", 32'(count), 32'd0);
      cmp("flush_empty", 32'(empty), 32'd1);
`ifdef ROW_FIFO_HIGH_WATER_EN
      cmp("flush_peak", 32'(peak), 32'd0);
`endif
      applyStimulus("post_flush", 1'b1, 25'h0000005, 1'b0, 1'b0, 1'b0);
      cmp("post_flush_head", 32'(out_data), 32'h5);

      // Reset mid-stream discards rows even with flush, push and pop all asserted.
      applyStimulus("mid_push", 1'b1, 25'h0000006, 1'b0, 1'b0, 1'b0);
      applyStimulus("mid_rst", 1'b1, 25'h0000055, 1'b1, 1'b1, 1'b1);
      rst = 1'b0; flush = 1'b0;
      cmp("mid_rst_count", 32'(count), 32'd0);
      applyStimulus("after_rst", 1'b1, 25'h0000077, 1'b0, 1'b0, 1'b0);
      cmp("after_rst_head", 32'(out_data), 32'h77);

      // High-water mark survives a drain and reflects the earlier maximum.
      doReset();
      for (int v = 1; v <= 3; v++) applyStimulus("hw_fill", 1'b1, WIDTH'(v), 1'b0, 1'b0, 1'b0);
      for (int v = 1; v <= 3; v++) applyStimulus("hw_drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
      for (int v = 1; v <= 2; v++) applyStimulus("hw_refill", 1'b1, WIDTH'(v + 8), 1'b0, 1'b0, 1'b0);
      applyStimulus("hw_idle", 1'b0, '0, 1'b0, 1'b0, 1'b0);
      cmp("hw_count", 32'(count), 32'd2);
`ifdef ROW_FIFO_HIGH_WATER_EN
      cmp("hw_peak", 32'(peak), 32'd3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
